// File: rtl/ir_prefetch_queue.sv
// Opcode prefetch queue feeding the instruction register: circular byte buffer with
// valid/ready push, TCU-timed IR load, interrupt opcode injection, flush and stall.
module ir_prefetch_queue #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 4,
  parameter int                    TCU_WIDTH     = 3,
  parameter int                    LOAD_STEP     = 1,
  parameter logic [DATA_WIDTH-1:0] INJECT_OPCODE = 8'h00,
  parameter bit                    BYPASS        = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_data_valid,
  output logic                       o_data_ready,
  input  logic [TCU_WIDTH-1:0]       i_tcu,
  input  logic                       i_interrupt,
  input  logic                       i_flush,
  output logic [DATA_WIDTH-1:0]      o_ir,
  output logic [DATA_WIDTH-1:0]      o_head,
  output logic                       o_head_valid,
  output logic                       o_stall,
  output logic                       o_interrupt_taken,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  int_taken_q, int_taken_d;

  logic not_empty;
  logic push;
  logic load;
  logic take_int;
  logic pop;
  logic bypass_take;
  logic enqueue;

  assign not_empty    = (count_q != '0);
  assign o_data_ready = (count_q < CNT_W'(DEPTH));
  assign push         = i_data_valid & o_data_ready & ~i_flush;
  assign load         = (i_tcu == TCU_WIDTH'(LOAD_STEP));

  // Load priority: interrupt injection, then queue head, then same-cycle bypass.
  assign take_int     = load & i_interrupt;
  assign pop          = load & ~i_interrupt & ~i_flush & not_empty;
  assign bypass_take  = BYPASS & load & ~i_interrupt & ~i_flush & ~not_empty & push;
  assign enqueue      = push & ~bypass_take;

  assign o_stall      = load & ~i_interrupt & ~(pop | bypass_take);

  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ir_d        = ir_q;
    int_taken_d = 1'b0;

    if (enqueue) begin
      mem_d[wr_ptr_q] = i_data;
    end

    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enqueue) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enqueue) - CNT_W'(pop);
    end

    if (take_int) begin
      ir_d        = INJECT_OPCODE;
      int_taken_d = 1'b1;
    end else if (pop) begin
      ir_d = mem_q[rd_ptr_q];
    end else if (bypass_take) begin
      ir_d = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ir_q        <= INJECT_OPCODE;
      int_taken_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ir_q        <= ir_d;
      int_taken_q <= int_taken_d;
    end
  end

  assign o_ir              = ir_q;
  assign o_head            = not_empty ? mem_q[rd_ptr_q] : '0;
  assign o_head_valid      = not_empty;
  assign o_interrupt_taken = int_taken_q;
  assign o_count           = count_q;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Scoreboard bench for ir_prefetch_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_ir_prefetch_queue;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [2:0] tcu;
  logic       intr;
  logic       flush;
  logic [7:0] ir;
  logic [7:0] head;
  logic       head_valid;
  logic       stall;
  logic       int_taken;
  logic [2:0] count;

  ir_prefetch_queue #(
    .DATA_WIDTH(8), .DEPTH(4), .TCU_WIDTH(3), .LOAD_STEP(1),
    .INJECT_OPCODE(8'h00), .BYPASS(1'b1)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_data_valid(valid),
    .o_data_ready(ready), .i_tcu(tcu), .i_interrupt(intr), .i_flush(flush),
    .o_ir(ir), .o_head(head), .o_head_valid(head_valid), .o_stall(stall),
    .o_interrupt_taken(int_taken), .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ir;
    logic [7:0] head;
    logic       hv;
    int         cnt;
    logic       rdy;
    logic       it;
  } exp_t;

  exp_t       eq[$];
  logic       sq[$];
  logic [7:0] mq[$];
  logic [7:0] m_ir;
  int         errs = 0;
  int         nchecks = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: one clock edge of the queue described at the byte/queue level.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] t,
                       input logic irq, input logic fl);
    int   sz;
    logic rdy, psh, ld, consumed, it;
    exp_t e;
    @(negedge clk);
    valid = v; data = d; tcu = t; intr = irq; flush = fl;
    sz  = mq.size();
    rdy = (sz < 4);
    psh = v & rdy & ~fl;
    ld  = (t == 3'd1);
    sq.push_back(ld & ~irq & ~(~fl & ((sz > 0) | psh)));
    consumed = 1'b0;
    it = ld & irq;
    if (ld && irq)                 m_ir = 8'h00;
    else if (ld && !fl && sz > 0)  m_ir = mq.pop_front();
    else if (ld && !fl && psh) begin
      m_ir = d;
      consumed = 1'b1;
    end
    if (fl)                   mq.delete();
    else if (psh && !consumed) mq.push_back(d);
    e.ir   = m_ir;
    e.cnt  = mq.size();
    e.hv   = (mq.size() > 0);
    e.head = (mq.size() > 0) ? mq[0] : 8'h00;
    e.rdy  = (mq.size() < 4);
    e.it   = it;
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (sq.size() > 0) check("stall", stall, sq.pop_front());
  end

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      check("ir", ir, e.ir);
      check("head", head, e.head);
      check("head_valid", head_valid, e.hv);
      check("count", count, e.cnt);
      check("data_ready", ready, e.rdy);
      check("interrupt_taken", int_taken, e.it);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0; valid = 1'b0; data = '0; tcu = '0; intr = 1'b0; flush = 1'b0;
    m_ir = 8'h00;
    #3;
    check("reset_ir", ir, 8'h00);
    check("reset_ready", ready, 1'b1);
    check("reset_stall", stall, 1'b0);
    #9 rst_n = 1'b1;

    // Fill three, peek, then load one.
    cycle(1, 8'hA9, 0, 0, 0);
    cycle(1, 8'h05, 0, 0, 0);
    cycle(1, 8'h8D, 0, 0, 0);
    check("t2_count", count, 3);
    check("t2_head", head, 8'hA9);
    cycle(0, 8'h00, 1, 0, 0);
    check("t2_ir", ir, 8'hA9);
    check("t2_head_after", head, 8'h05);
    check("t2_count_after", count, 2);

    // Asynchronous reset in the middle of a cycle with three bytes queued.
    cycle(1, 8'h11, 0, 0, 0);
    check("t1_count_before", count, 3);
    #2 rst_n = 1'b0;
    valid = 1'b0; tcu = '0;
    #1;
    check("t1_ir", ir, 8'h00);
    check("t1_count", count, 0);
    check("t1_ready", ready, 1'b1);
    check("t1_head_valid", head_valid, 1'b0);
    check("t1_int_taken", int_taken, 1'b0);
    mq.delete();
    m_ir = 8'h00;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Full queue, ignored fifth byte, pop, and wrap-around with push+pop.
    cycle(1, 8'h01, 0, 0, 0);
    cycle(1, 8'h02, 0, 0, 0);
    cycle(1, 8'h03, 0, 0, 0);
    cycle(1, 8'h04, 0, 0, 0);
    check("t3_full_ready", ready, 1'b0);
    cycle(1, 8'hFF, 0, 0, 0);
    check("t3_fifth_ignored", count, 4);
    cycle(1, 8'hFE, 1, 0, 0);
    check("t3_pop_ir", ir, 8'h01);
    check("t3_ready_after_pop", ready, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1, 8'h40 + 8'(i), 1, 0, 0);
    check("t3_wrap_count", count, 3);

    // Drain, stall on empty, then same-cycle bypass.
    guard = 0;
    while (mq.size() > 0 && guard < 10) begin
      cycle(0, 8'h00, 1, 0, 0);
      guard++;
    end
    check("t4_empty", count, 0);
    cycle(0, 8'h00, 1, 0, 0);
    check("t4_ir_hold", ir, m_ir);
    cycle(1, 8'hEA, 1, 0, 0);
    check("t4_bypass_ir", ir, 8'hEA);
    check("t4_bypass_count", count, 0);

    // Interrupt injection with two bytes queued.
    cycle(1, 8'h20, 0, 0, 0);
    cycle(1, 8'h4C, 0, 0, 0);
    cycle(0, 8'h00, 1, 1, 0);
    check("t5_ir", ir, 8'h00);
    check("t5_taken", int_taken, 1'b1);
    check("t5_count", count, 2);
    cycle(0, 8'h00, 0, 0, 0);
    check("t5_taken_drop", int_taken, 1'b0);

    // Flush beats push and load.
    cycle(1, 8'h60, 1, 0, 1);
    check("t6_count", count, 0);
    check("t6_ir_hold", ir, 8'h00);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 9) < 7),
            8'($urandom),
            (($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7))),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 12) == 0));
    end

    valid = 1'b0; tcu = '0; intr = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", eq.size() + sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchecks);
    $finish;
  end

endmodule
